// File: rtl/regfile_pkg.sv
// Shared types, defaults and the write-port priority resolver for the multi-port register file.
package regfile_pkg;

  localparam int unsigned XLEN_DEF  = 32;
  localparam int unsigned NREGS_DEF = 32;
  // Upper bound on write ports that sel_write can arbitrate.
  localparam int unsigned NWR_MAX   = 8;

  typedef enum logic {RF_IDLE, RF_SWEEP} rf_state_e;

  // Returns the highest-index set bit of hit, or -1 when no port targets the address.
  function automatic int sel_write(input logic [NWR_MAX-1:0] hit);
    int sel;
    sel = -1;
    for (int i = 0; i < NWR_MAX; i++) begin
      if (hit[i]) sel = i;
    end
    return sel;
  endfunction

endpackage

// File: rtl/regfile_mp_if.sv
// Decode/writeback-facing bus of the register file: reads, reservations, writes and flush control.
interface regfile_mp_if
  import regfile_pkg::*;
#(
  parameter int unsigned XLEN  = XLEN_DEF,
  parameter int unsigned NREGS = NREGS_DEF,
  parameter int unsigned NRD   = 2,
  parameter int unsigned NWR   = 2
);
  localparam int unsigned AW = $clog2(NREGS);

  logic [NRD*AW-1:0]   rd_addr;
  logic [NRD*XLEN-1:0] rd_data;
  logic [NRD-1:0]      rd_busy;
  logic                rsv_valid;
  logic [AW-1:0]       rsv_addr;
  logic [NWR-1:0]      wr_valid;
  logic [NWR*AW-1:0]   wr_addr;
  logic [NWR*XLEN-1:0] wr_data;
  logic                flush_req;
  logic                flush_busy;

  modport master (
    output rd_addr, rsv_valid, rsv_addr, wr_valid, wr_addr, wr_data, flush_req,
    input  rd_data, rd_busy, flush_busy
  );

  modport slave (
    input  rd_addr, rsv_valid, rsv_addr, wr_valid, wr_addr, wr_data, flush_req,
    output rd_data, rd_busy, flush_busy
  );

endinterface

// File: rtl/regfile_scoreboard.sv
// Per-register busy bits for in-flight results, with a combinational next-busy lookup per read port.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int unsigned NREGS = NREGS_DEF,
  parameter int unsigned NRD   = 2,
  parameter int unsigned NWR   = 2,
  localparam int unsigned AW   = $clog2(NREGS)
) (
  input  logic              clk,
  input  logic              clrn,
  input  logic              upd_en,
  input  logic              flush_en,
  input  logic [AW-1:0]     flush_idx,
  input  logic              rsv_valid,
  input  logic [AW-1:0]     rsv_addr,
  input  logic [NWR-1:0]    wr_valid,
  input  logic [NWR*AW-1:0] wr_addr,
  input  logic [NRD*AW-1:0] rd_addr,
  output logic [NRD-1:0]    busy_next
);

  logic [NREGS-1:0] busy_q;
  logic [NREGS-1:0] busy_d;

  // Flush clears first; otherwise a reservation beats a completing write (newer producer).
  always_comb begin
    busy_d = busy_q;
    for (int r = 1; r < NREGS; r++) begin
      if (flush_en && (flush_idx == AW'(r))) begin
        busy_d[r] = 1'b0;
      end else if (upd_en) begin
        if (rsv_valid && (rsv_addr == AW'(r))) begin
          busy_d[r] = 1'b1;
        end else begin
          for (int w = 0; w < NWR; w++) begin
            if (wr_valid[w] && (wr_addr[w*AW +: AW] == AW'(r))) busy_d[r] = 1'b0;
          end
        end
      end
    end
    busy_d[0] = 1'b0;
  end

  // Busy state register.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

  // Post-update busy view for each read port.
  always_comb begin
    busy_next = '0;
    for (int p = 0; p < NRD; p++) begin
      busy_next[p] = busy_d[rd_addr[p*AW +: AW]];
    end
  end

endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file with write-first bypass, busy scoreboard and sequenced soft flush.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int unsigned XLEN  = XLEN_DEF,
  parameter int unsigned NREGS = NREGS_DEF,
  parameter int unsigned NRD   = 2,
  parameter int unsigned NWR   = 2,
  localparam int unsigned AW   = $clog2(NREGS)
) (
  input logic         clk,
  input logic         clrn,
  regfile_mp_if.slave bus
);

  rf_state_e           state_q;
  logic [AW-1:0]       idx_q;
  logic                flush_busy_q;
  logic [XLEN-1:0]     regs_q [NREGS];
  logic [NREGS-1:0]    reg_we;
  logic [XLEN-1:0]     reg_wd [NREGS];
  logic [NRD*XLEN-1:0] rd_data_q, rd_data_d;
  logic [NRD-1:0]      rd_busy_q, rd_busy_d;
  logic [NRD-1:0]      busy_next;
  logic                idle, sweeping;

  assign idle     = (state_q == RF_IDLE);
  assign sweeping = (state_q == RF_SWEEP);

  // Resolve per-register write enable and data; highest-index port wins a collision.
  always_comb begin
    logic [NWR_MAX-1:0] hit;
    int                 sel;
    hit = '0;
    sel = -1;
    for (int r = 0; r < NREGS; r++) begin
      hit = '0;
      for (int w = 0; w < NWR; w++) begin
        hit[w] = bus.wr_valid[w] && (bus.wr_addr[w*AW +: AW] == AW'(r));
      end
      sel       = sel_write(hit);
      reg_we[r] = idle && (r != 0) && (sel >= 0);
      reg_wd[r] = '0;
      for (int w = 0; w < NWR; w++) begin
        if (sel == w) reg_wd[r] = bus.wr_data[w*XLEN +: XLEN];
      end
    end
  end

  // Register array: sweep clear takes precedence, x0 is never written.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      for (int r = 0; r < NREGS; r++) regs_q[r] <= '0;
    end else begin
      for (int r = 1; r < NREGS; r++) begin
        if (sweeping && (idx_q == AW'(r))) begin
          regs_q[r] <= '0;
        end else if (reg_we[r]) begin
          regs_q[r] <= reg_wd[r];
        end
      end
    end
  end

  // Read path with write-first bypass; a running sweep forces 0 data and busy=1.
  always_comb begin
    logic [NWR_MAX-1:0] hit;
    logic [AW-1:0]      ra;
    int                 sel;
    hit       = '0;
    ra        = '0;
    sel       = -1;
    rd_data_d = '0;
    rd_busy_d = '0;
    for (int p = 0; p < NRD; p++) begin
      ra  = bus.rd_addr[p*AW +: AW];
      hit = '0;
      for (int w = 0; w < NWR; w++) begin
        hit[w] = bus.wr_valid[w] && (bus.wr_addr[w*AW +: AW] == ra);
      end
      sel = sel_write(hit);
      if (sweeping) begin
        rd_busy_d[p] = 1'b1;
      end else begin
        rd_busy_d[p] = busy_next[p];
        if (ra != '0) begin
          rd_data_d[p*XLEN +: XLEN] = regs_q[ra];
          for (int w = 0; w < NWR; w++) begin
            if (sel == w) rd_data_d[p*XLEN +: XLEN] = bus.wr_data[w*XLEN +: XLEN];
          end
        end
      end
    end
  end

  // Registered read outputs.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      rd_data_q <= '0;
      rd_busy_q <= '0;
    end else begin
      rd_data_q <= rd_data_d;
      rd_busy_q <= rd_busy_d;
    end
  end

  // Flush FSM: walks idx over x1..x(NREGS-1), one register per cycle.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state_q      <= RF_IDLE;
      idx_q        <= AW'(1);
      flush_busy_q <= 1'b0;
    end else begin
      unique case (state_q)
        RF_IDLE: begin
          if (bus.flush_req) begin
            state_q      <= RF_SWEEP;
            flush_busy_q <= 1'b1;
          end
        end
        RF_SWEEP: begin
          if (idx_q == AW'(NREGS - 1)) begin
            state_q      <= RF_IDLE;
            idx_q        <= AW'(1);
            flush_busy_q <= 1'b0;
          end else begin
            idx_q <= idx_q + AW'(1);
          end
        end
        default: begin
          state_q      <= RF_IDLE;
          idx_q        <= AW'(1);
          flush_busy_q <= 1'b0;
        end
      endcase
    end
  end

  regfile_scoreboard #(
    .NREGS (NREGS),
    .NRD   (NRD),
    .NWR   (NWR)
  ) u_scoreboard (
    .clk       (clk),
    .clrn      (clrn),
    .upd_en    (idle),
    .flush_en  (sweeping),
    .flush_idx (idx_q),
    .rsv_valid (bus.rsv_valid),
    .rsv_addr  (bus.rsv_addr),
    .wr_valid  (bus.wr_valid),
    .wr_addr   (bus.wr_addr),
    .rd_addr   (bus.rd_addr),
    .busy_next (busy_next)
  );

  assign bus.rd_data    = rd_data_q;
  assign bus.rd_busy    = rd_busy_q;
  assign bus.flush_busy = flush_busy_q;

endmodule

// File: doc/regfile_mp.md
Name: regfile_mp

Overview:
Parametrised multi-port integer register file. It is the successor to the single-write, two-read core register file.
- Adds configurable width, depth and port counts.
- Adds write-first bypass and a per-register busy scoreboard for in-flight results.
- Adds a sequenced soft-flush engine.
- Sits between the decode stage (reads, reservations) and writeback (writes).

Parameters:
XLEN, 32, data width of each register
NREGS, 32, number of architectural registers including x0 (power of two, >= 4)
NRD, 2, number of read ports
NWR, 2, number of write ports
AW, $clog2(NREGS), address width (derived localparam, not overridable)

Ports:
clk  in  1  clock, all state updates on rising edge
clrn  in  1  asynchronous active-low reset
rd_addr  in  NRD*AW  packed read addresses, port p at [p*AW +: AW]
rd_data  out  NRD*XLEN  registered read data, port p at [p*XLEN +: XLEN]
rd_busy  out  NRD  registered busy flag of the addressed register
rsv_valid  in  1  reserve destination (set busy)
rsv_addr  in  AW  register to reserve
wr_valid  in  NWR  per-port write enable
wr_addr  in  NWR*AW  packed write addresses
wr_data  in  NWR*XLEN  packed write data
flush_req  in  1  start soft flush (single-cycle pulse or level)
flush_busy  out  1  high while the flush sweep runs

Behaviour:
- Reset (clrn=0, async):
  - All registers 0, all busy bits 0.
  - rd_data=0, rd_busy=0, flush_busy=0, FSM=IDLE, sweep index=1.
- x0:
  - Always reads 0 and is never busy.
  - Writes and reservations targeting x0 are dropped.
- Write (IDLE only):
  - At the rising edge, each port with wr_valid=1 and wr_addr!=0 updates its register.
  - Same-address collision: the highest-index port wins.
- Read latency is 1 cycle. rd_data[p] at edge k+1 reflects rd_addr[p] sampled at edge k.
- Bypass, write-first: if a write to the same address occurs at the same edge, rd_data gets that write data, using the same highest-index priority.
- Scoreboard:
  - rsv_valid sets busy[rsv_addr]. Any valid write clears busy[wr_addr].
  - Reservation and write to the same address at the same edge: busy ends set (the new producer wins), data is still written.
- rd_busy[p] is registered with rd_data. It shows the busy value after the same edge's updates (post-bypass view).
- FSM IDLE:
  - flush_req=1 -> SWEEP. flush_busy rises at the next edge.
  - A write or reservation in the same cycle as flush_req is still applied.
- FSM SWEEP:
  - Each cycle, register[idx]=0 and busy[idx]=0, then idx++.
  - When idx=NREGS-1 is cleared -> IDLE, idx=1, flush_busy falls the following cycle.
  - Duration is exactly NREGS-1 cycles.
- During SWEEP:
  - wr_valid and rsv_valid are ignored.
  - flush_req is ignored (no restart).
  - Reads return rd_data=0 and rd_busy=1 on every port.
- clrn asserted mid-sweep: immediate full reset as above. The FSM returns to IDLE.
- Widths: no arithmetic except the sweep counter. The counter is AW bits and never wraps past NREGS-1.

Decomposition:
- Package regfile_pkg:
  - Defaults XLEN_DEF, NREGS_DEF.
  - typedef enum logic {RF_IDLE, RF_SWEEP} rf_state_e.
  - Function sel_write(), which resolves the highest-index write port for an address (shared by the array update and the bypass).
- One sub-module: regfile_scoreboard.
  - Owns the NREGS busy bits and the set/clear/flush priority.
  - Provides a combinational next-busy lookup per read port.
- Array, bypass and FSM stay in regfile_mp.

Test Plan:
- Reset then write x5=0xDEADBEEF via port 0; read x5 on port 1 next cycle -> rd_data=0xDEADBEEF, rd_busy=0.
- Same cycle: port 0 writes x7=0x11, port 1 writes x7=0x22, read x7 -> rd_data=0x22 (bypass, port 1 wins); next read x7 also 0x22.
- Write x0=0xFFFFFFFF, and reserve x0 -> reads of x0 give 0, rd_busy=0.
- Reserve x3 -> rd_busy=1; write x3=0x5 with rsv x3 same cycle -> data 0x5, busy stays 1; later write without rsv -> busy 0.
- Fill x1..x31 with index values, pulse flush_req:
  - flush_busy is high for exactly 31 cycles.
  - Writes during the sweep are ignored and reads return 0/busy=1.
  - After the sweep all registers read 0.
- Assert clrn low at sweep cycle 10 -> all outputs 0 immediately; after release a write/read of x9=0x99 works normally.
